// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: fractional-rate sample tick generator, two-source
// sample arbiter and DAC frame sequencer in front of the SPI DAC driver.
// The tick comes from a phase accumulator, so on average exactly F_SAMPLE
// ticks are produced per F_CLK clock cycles. Each tick either starts one
// DAC frame from the selected source or, when a frame is still running,
// is recorded as a missed frame.
module dac_sample_scheduler #(
    parameter int                  SIG_BITS = 16,
    parameter int                  SPI_BITS = 24,
    parameter int                  F_CLK    = 50_000_000,
    parameter int                  F_SAMPLE = 48_000,
    parameter int                  CNT_BITS = 16,
    parameter logic [SIG_BITS-1:0] MID_CODE = 16'h8000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SIG_BITS-1:0] aud_data,
    input  logic                aud_valid,
    output logic                aud_ready,
    input  logic [SIG_BITS-1:0] aux_data,
    input  logic                aux_valid,
    output logic                aux_ready,
    input  logic                aux_sel,
    output logic [SPI_BITS-1:0] spi_in,
    output logic                spi_go,
    input  logic                spi_busy,
    output logic                tick,
    output logic [CNT_BITS-1:0] underrun_cnt,
    output logic [CNT_BITS-1:0] miss_cnt
);

    // The accumulator stays below F_CLK, so acc + F_SAMPLE < 2*F_CLK fits
    // in one extra bit above clog2(F_CLK).
    localparam int                  ACC_BITS = $clog2(F_CLK) + 1;
    localparam int                  PAD_BITS = SPI_BITS - SIG_BITS - 2;
    localparam logic [ACC_BITS-1:0] F_CLK_A  = ACC_BITS'(F_CLK);
    localparam logic [ACC_BITS-1:0] F_SMP_A  = ACC_BITS'(F_SAMPLE);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [ACC_BITS-1:0] acc_q;
    logic [ACC_BITS-1:0] acc_sum;
    logic [ACC_BITS-1:0] acc_d;
    logic                tick_w;

    assign acc_sum = acc_q + F_SMP_A;
    assign tick_w  = (acc_sum >= F_CLK_A);
    assign acc_d   = tick_w ? (acc_sum - F_CLK_A) : acc_sum;

    // Advance the phase accumulator every clock; wrap by F_CLK on a tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Holding registers: index 0 = audio, index 1 = aux
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                start_frame;
    logic [1:0]          src_valid;
    logic [1:0]          sel_onehot;
    logic [1:0]          consume;
    logic [1:0]          full_vec;
    logic [SIG_BITS-1:0] src_data  [2];
    logic [SIG_BITS-1:0] hold_data [2];
    logic                sel_full;
    logic [SIG_BITS-1:0] sel_data;

    // A frame only starts on a tick seen while the sequencer is idle.
    assign start_frame = tick_w && (state_q == S_IDLE);
    assign src_valid   = {aux_valid, aud_valid};
    assign sel_onehot  = {aux_sel, ~aux_sel};
    assign src_data[0] = aud_data;
    assign src_data[1] = aux_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hold
            logic                full_q;
            logic [SIG_BITS-1:0] data_q;

            // Consumption requires full and acceptance requires empty,
            // so the two can never coincide on one register.
            assign consume[gi] = start_frame && sel_onehot[gi] && full_q;

            // Capture an offered sample when empty; release it only when a tick consumes it
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                end else if (src_valid[gi] && !full_q) begin
                    full_q <= 1'b1;
                    data_q <= src_data[gi];
                end else if (consume[gi]) begin
                    full_q <= 1'b0;
                end
            end

            assign full_vec[gi]  = full_q;
            assign hold_data[gi] = data_q;
        end
    endgenerate

    assign sel_full  = full_vec[aux_sel];
    assign sel_data  = aux_sel ? hold_data[1] : hold_data[0];
    assign aud_ready = ~full_vec[0];
    assign aux_ready = ~full_vec[1];

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic [SIG_BITS-1:0] last_sample_q;
    logic [SPI_BITS-1:0] spi_in_q;
    logic                spi_go_q;
    logic [1:0]          wait_q;
    logic [CNT_BITS-1:0] underrun_q;
    logic [CNT_BITS-1:0] miss_q;
    logic [SPI_BITS-1:0] frame_w;

    // Frame layout: two zero command bits, the sample, then zero padding.
    assign frame_w = SPI_BITS'(last_sample_q) << PAD_BITS;

    // Pick a sample on an idle tick, load and strobe the frame, then track the driver's busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_sample_q <= MID_CODE;
            spi_in_q      <= '0;
            spi_go_q      <= 1'b0;
            wait_q        <= '0;
            underrun_q    <= '0;
            miss_q        <= '0;
        end else begin
            spi_go_q <= 1'b0;

            // A tick arriving mid-frame is dropped but still counted.
            if (tick_w && (state_q != S_IDLE) && (miss_q != CNT_MAX)) begin
                miss_q <= miss_q + CNT_BITS'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (tick_w) begin
                        if (sel_full) begin
                            last_sample_q <= sel_data;
                        end else if (underrun_q != CNT_MAX) begin
                            underrun_q <= underrun_q + CNT_BITS'(1);
                        end
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_in_q <= frame_w;
                    spi_go_q <= 1'b1;
                    state_q  <= S_GO;
                end
                S_GO: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Give the driver four cycles to raise busy; if it never
                    // does, assume it already finished or is absent.
                    if (spi_busy || (wait_q == 2'd3)) begin
                        state_q <= S_WAIT_DONE;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_in       = spi_in_q;
    assign spi_go       = spi_go_q;
    assign tick         = tick_w;
    assign underrun_cnt = underrun_q;
    assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Testbench for dac_sample_scheduler: a cycle-level reference model built
// from the arithmetic tick rule and per-frame durations, a table of
// per-tick frame vectors, directed corner-case sequences and a random phase.
module tb_dac_sample_scheduler;

    localparam int          SIG = 16;
    localparam int          SPI = 24;
    localparam int          FC  = 100;
    localparam int          FS  = 3;
    localparam int          CB  = 4;
    localparam logic [15:0] MID = 16'h8000;
    localparam int          CMAX = (1 << CB) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [SIG-1:0] aud_data = '0;
    logic           aud_valid = 1'b0;
    logic           aud_ready;
    logic [SIG-1:0] aux_data = '0;
    logic           aux_valid = 1'b0;
    logic           aux_ready;
    logic           aux_sel = 1'b0;
    logic [SPI-1:0] spi_in;
    logic           spi_go;
    logic           spi_busy = 1'b0;
    logic           tick;
    logic [CB-1:0]  underrun_cnt;
    logic [CB-1:0]  miss_cnt;

    dac_sample_scheduler #(
        .SIG_BITS (SIG),
        .SPI_BITS (SPI),
        .F_CLK    (FC),
        .F_SAMPLE (FS),
        .CNT_BITS (CB),
        .MID_CODE (MID)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .aud_data     (aud_data),
        .aud_valid    (aud_valid),
        .aud_ready    (aud_ready),
        .aux_data     (aux_data),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_sel      (aux_sel),
        .spi_in       (spi_in),
        .spi_go       (spi_go),
        .spi_busy     (spi_busy),
        .tick         (tick),
        .underrun_cnt (underrun_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_prints = 0;

    // Reference model state
    longint      n;
    bit          m_full [2];
    logic [15:0] m_data [2];
    logic [15:0] m_last;
    int          m_under, m_miss;
    longint      m_idle_at, m_go_at, m_load_at;
    int          m_fb;
    logic [23:0] m_spi_in, m_load_val;
    int          cur_busy_len = 10;

    // Observations
    bit     obs_go, obs_tick;
    int     tick_count, spacing_bad;
    longint last_tick_n, go_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            if (fail_prints < 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n);
            fail_prints++;
        end
    endtask

    // Tick k fires when the running total k*FS/FC crosses an integer.
    function automatic bit tick_at(input longint k);
        return ((k + 1) * FS) / FC != (k * FS) / FC;
    endfunction

    task automatic model_reset();
        n = 0;
        m_full[0] = 0; m_full[1] = 0;
        m_data[0] = '0; m_data[1] = '0;
        m_last = MID;
        m_under = 0; m_miss = 0;
        m_idle_at = 0; m_go_at = -1000; m_load_at = -1;
        m_fb = 0;
        m_spi_in = '0; m_load_val = '0;
        tick_count = 0; spacing_bad = 0; last_tick_n = -1; go_n = -1;
    endtask

    // One clock: drive busy, compare, advance model with current inputs, wait next negedge.
    task automatic step();
        bit pre_full [2];
        int s;
        spi_busy = (n > m_go_at) && (n <= m_go_at + m_fb);
        check("tick", tick, tick_at(n));
        check("aud_ready", aud_ready, !m_full[0]);
        check("aux_ready", aux_ready, !m_full[1]);
        check("spi_go", spi_go, n == m_go_at);
        check("spi_in", spi_in, m_spi_in);
        check("underrun_cnt", underrun_cnt, m_under);
        check("miss_cnt", miss_cnt, m_miss);
        obs_go = spi_go;
        obs_tick = tick;
        if (tick) begin
            tick_count++;
            if (last_tick_n >= 0 && (n - last_tick_n) != 33 && (n - last_tick_n) != 34)
                spacing_bad++;
            last_tick_n = n;
        end
        if (spi_go) begin
            go_n = n;
            $display("frame cycle=%0d spi_in=%06h underrun=%0d miss=%0d", n, spi_in, underrun_cnt, miss_cnt);
        end
        pre_full[0] = m_full[0];
        pre_full[1] = m_full[1];
        if (tick_at(n)) begin
            if (n >= m_idle_at) begin
                s = aux_sel ? 1 : 0;
                if (m_full[s]) begin
                    m_last = m_data[s];
                    m_full[s] = 0;
                end else if (m_under < CMAX) begin
                    m_under++;
                end
                m_go_at = n + 2;
                m_load_at = n + 2;
                m_load_val = 24'(m_last) << 6;
                m_fb = cur_busy_len;
                m_idle_at = n + ((m_fb > 0) ? (m_fb + 4) : 8);
            end else if (m_miss < CMAX) begin
                m_miss++;
            end
        end
        if (aud_valid && !pre_full[0]) begin m_full[0] = 1; m_data[0] = aud_data; end
        if (aux_valid && !pre_full[1]) begin m_full[1] = 1; m_data[1] = aux_data; end
        n++;
        if (n == m_load_at) m_spi_in = m_load_val;
        @(negedge clk);
    endtask

    task automatic wait_go(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            found = obs_go;
        end
        check("wait_go", found, 1'b1);
    endtask

    task automatic wait_tick(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            found = obs_tick;
        end
        check("wait_tick", found, 1'b1);
    endtask

    task automatic push(input bit pa, input logic [15:0] a, input bit px, input logic [15:0] x);
        aud_valid = pa; aud_data = a;
        aux_valid = px; aux_data = x;
        step();
        aud_valid = 0; aux_valid = 0;
    endtask

    task automatic do_reset();
        aud_valid = 0; aux_valid = 0; spi_busy = 0;
        reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    typedef struct {
        bit          push_aud;
        logic [15:0] aud;
        bit          push_aux;
        logic [15:0] aux;
        bit          sel;
        int          busy_len;
        logic [23:0] exp_spi;
        int          exp_under;
        bit          exp_aud_ready;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 16'h0000, 0, 16'h0000, 0, 10, 24'h200000, 1, 1};
        tbl[1] = '{0, 16'h0000, 0, 16'h0000, 0, 10, 24'h200000, 2, 1};
        tbl[2] = '{0, 16'h0000, 0, 16'h0000, 0, 10, 24'h200000, 3, 1};
        tbl[3] = '{1, 16'h1234, 0, 16'h0000, 0, 10, 24'h048D00, 3, 1};
        tbl[4] = '{1, 16'h0001, 1, 16'hFFFF, 1, 10, 24'h3FFFC0, 3, 0};
        tbl[5] = '{0, 16'h0000, 0, 16'h0000, 0, 10, 24'h000040, 3, 1};
        tbl[6] = '{0, 16'h0000, 0, 16'h0000, 1, 0,  24'h000040, 4, 1};
        tbl[7] = '{1, 16'hABCD, 0, 16'h0000, 0, 10, 24'h2AF340, 4, 1};

        model_reset();
        @(negedge clk);
        #1;
        check("rst_spi_go", spi_go, 1'b0);
        check("rst_aud_ready", aud_ready, 1'b1);
        check("rst_aux_ready", aux_ready, 1'b1);
        @(negedge clk);
        do_reset();

        // Tick rate: 1000 cycles must give exactly 30 ticks spaced 33 or 34
        cur_busy_len = 10;
        for (int i = 0; i < 1000; i++) step();
        check("tick_count_1000", tick_count, 30);
        check("tick_spacing", spacing_bad, 0);

        // Table of per-tick frames
        do_reset();
        for (int r = 0; r < 8; r++) begin
            aux_sel = tbl[r].sel;
            cur_busy_len = tbl[r].busy_len;
            if (tbl[r].push_aud || tbl[r].push_aux)
                push(tbl[r].push_aud, tbl[r].aud, tbl[r].push_aux, tbl[r].aux);
            wait_go(80);
            check($sformatf("vec%0d_spi_in", r), spi_in, tbl[r].exp_spi);
            check($sformatf("vec%0d_underrun", r), underrun_cnt, tbl[r].exp_under);
            check($sformatf("vec%0d_tick_to_go", r), go_n - last_tick_n, 2);
            check($sformatf("vec%0d_aud_ready", r), aud_ready, tbl[r].exp_aud_ready);
        end

        // Busy held across the next tick: miss, sample kept, sent on the following tick
        aux_sel = 0;
        cur_busy_len = 45;
        wait_go(80);
        push(1, 16'h5555, 0, 16'h0000);
        cur_busy_len = 10;
        wait_tick(60);
        check("miss_after_busy", miss_cnt, 1);
        check("miss_aud_kept", aud_ready, 1'b0);
        wait_go(80);
        check("miss_next_spi_in", spi_in, 24'h155540);
        check("miss_next_aud_ready", aud_ready, 1'b1);

        // Reset asserted during WAIT_DONE
        push(1, 16'h7777, 0, 16'h0000);
        cur_busy_len = 20;
        wait_go(80);
        repeat (5) step();
        reset_n = 0;
        #1;
        check("async_rst_spi_go", spi_go, 1'b0);
        check("async_rst_spi_in", spi_in, 24'h0);
        check("async_rst_tick", tick, 1'b0);
        check("async_rst_aud_ready", aud_ready, 1'b1);
        check("async_rst_aux_ready", aux_ready, 1'b1);
        check("async_rst_underrun", underrun_cnt, 0);
        check("async_rst_miss", miss_cnt, 0);
        @(negedge clk);
        do_reset();
        cur_busy_len = 5;
        wait_go(80);
        check("post_rst_spi_in", spi_in, 24'h200000);
        check("post_rst_underrun", underrun_cnt, 1);

        // Random traffic against the model; counters reach saturation here
        for (int i = 0; i < 3000; i++) begin
            aud_valid = ($urandom_range(0, 39) == 0);
            aud_data = 16'($urandom);
            aux_valid = ($urandom_range(0, 39) == 0);
            aux_data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) aux_sel = ~aux_sel;
            cur_busy_len = $urandom_range(0, 50);
            step();
        end
        aud_valid = 0;
        aux_valid = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
